// File: rtl/ch_addr_gen.sv
// Multi-channel burst address generator: one 64-bit burst start address per cycle.
// Optional macro CH_ADDR_GEN_INTERLEAVE_EN selects burst-major emission order.
module ch_addr_gen #(
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned CH_SHIFT    = 28,
  parameter int unsigned BURST_SHIFT = 12,
  parameter int unsigned NBURST_W    = 16,
  parameter int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                i_cmd_valid,
  output logic                i_cmd_ready,
  input  logic [63:0]         i_cmd_base,
  input  logic [NBURST_W-1:0] i_cmd_nburst,
  output logic                o_addr_valid,
  input  logic                o_addr_ready,
  output logic [63:0]         o_addr,
  output logic [CH_W-1:0]     o_addr_ch,
  output logic                o_addr_last_ch,
  output logic                o_addr_last,
  output logic                o_busy
);

  localparam logic [63:0]     CH_STEP    = 64'(1) << CH_SHIFT;
  localparam logic [63:0]     BURST_STEP = 64'(1) << BURST_SHIFT;
  localparam logic [CH_W-1:0] CH_MAX     = CH_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  state_e              state_q;
  logic [NBURST_W-1:0] nburst_q;
  logic [NBURST_W-1:0] idx_q, idx_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  // Base of the current outer-loop segment (channel base or round base).
  logic [63:0]         seg_q, seg_d;
  logic [63:0]         addr_q, addr_d;
  logic                valid_q;
  logic                last_ch_q, last_ch_d;
  logic                last_q, last_d;

  logic                cmd_accept;
  logic                addr_hs;
  logic [NBURST_W-1:0] nburst_last;

  assign i_cmd_ready    = (state_q == IDLE) && !areset;
  assign cmd_accept     = i_cmd_valid && i_cmd_ready;
  assign addr_hs        = valid_q && o_addr_ready;
  assign nburst_last    = nburst_q - NBURST_W'(1);

  assign o_addr_valid   = valid_q;
  assign o_addr         = addr_q;
  assign o_addr_ch      = ch_q;
  assign o_addr_last_ch = last_ch_q;
  assign o_addr_last    = last_q;
  assign o_busy         = (state_q == GEN);

  // Counter stepping and next address; each register path sees one 64-bit adder.
  always_comb begin
    idx_d  = idx_q;
    ch_d   = ch_q;
    seg_d  = seg_q;
    addr_d = addr_q;
`ifdef CH_ADDR_GEN_INTERLEAVE_EN
    if (ch_q != CH_MAX) begin
      ch_d   = ch_q + CH_W'(1);
      addr_d = addr_q + CH_STEP;
    end else begin
      ch_d   = '0;
      idx_d  = idx_q + NBURST_W'(1);
      seg_d  = seg_q + BURST_STEP;
      addr_d = seg_d;
    end
`else
    if (idx_q != nburst_last) begin
      idx_d  = idx_q + NBURST_W'(1);
      addr_d = addr_q + BURST_STEP;
    end else begin
      idx_d  = '0;
      ch_d   = ch_q + CH_W'(1);
      seg_d  = seg_q + CH_STEP;
      addr_d = seg_d;
    end
`endif
    last_ch_d = (idx_d == nburst_last);
    last_d    = last_ch_d && (ch_d == CH_MAX);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      nburst_q  <= '0;
      idx_q     <= '0;
      ch_q      <= '0;
      seg_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      last_ch_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_accept && (i_cmd_nburst != '0)) begin
            state_q   <= GEN;
            nburst_q  <= i_cmd_nburst;
            idx_q     <= '0;
            ch_q      <= '0;
            seg_q     <= i_cmd_base;
            addr_q    <= i_cmd_base;
            valid_q   <= 1'b1;
            last_ch_q <= (i_cmd_nburst == NBURST_W'(1));
            // NUM_CH >= 2, so the first address is never the last one.
            last_q    <= 1'b0;
          end
        end
        GEN: begin
          if (addr_hs) begin
            if (last_q) begin
              state_q   <= IDLE;
              valid_q   <= 1'b0;
              last_ch_q <= 1'b0;
              last_q    <= 1'b0;
            end else begin
              idx_q     <= idx_d;
              ch_q      <= ch_d;
              seg_q     <= seg_d;
              addr_q    <= addr_d;
              last_ch_q <= last_ch_d;
              last_q    <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_addr_gen.sv
// Self-checking bench for ch_addr_gen (NUM_CH=4); follows CH_ADDR_GEN_INTERLEAVE_EN for order.
module tb_ch_addr_gen;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CH_SHIFT    = 28;
  localparam int unsigned BURST_SHIFT = 12;
  localparam int unsigned NBURST_W    = 16;
  localparam int unsigned CH_W        = 2;

  logic                aclk;
  logic                areset;
  logic                i_cmd_valid;
  logic                i_cmd_ready;
  logic [63:0]         i_cmd_base;
  logic [NBURST_W-1:0] i_cmd_nburst;
  logic                o_addr_valid;
  logic                o_addr_ready;
  logic [63:0]         o_addr;
  logic [CH_W-1:0]     o_addr_ch;
  logic                o_addr_last_ch;
  logic                o_addr_last;
  logic                o_busy;

  ch_addr_gen #(
    .NUM_CH      (NUM_CH),
    .CH_SHIFT    (CH_SHIFT),
    .BURST_SHIFT (BURST_SHIFT),
    .NBURST_W    (NBURST_W)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd_ready    (i_cmd_ready),
    .i_cmd_base     (i_cmd_base),
    .i_cmd_nburst   (i_cmd_nburst),
    .o_addr_valid   (o_addr_valid),
    .o_addr_ready   (o_addr_ready),
    .o_addr         (o_addr),
    .o_addr_ch      (o_addr_ch),
    .o_addr_last_ch (o_addr_last_ch),
    .o_addr_last    (o_addr_last),
    .o_busy         (o_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0]     addr;
    logic [CH_W-1:0] ch;
    logic            last_ch;
    logic            last;
  } exp_t;

  typedef struct {
    logic [63:0] base;
    int unsigned n;
    int          stall_at;
    int          stall_len;
    int          exp_cnt;
    logic [63:0] exp_last;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[4];
  int          checks;
  int          errors;
  int          hs_cnt;
  logic        last_seen;
  logic [63:0] last_addr;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference order built from nested loops and direct shifts.
  task automatic push_cmd(input logic [63:0] base, input int unsigned n);
    exp_t e;
`ifdef CH_ADDR_GEN_INTERLEAVE_EN
    for (int i = 0; i < int'(n); i++)
      for (int c = 0; c < int'(NUM_CH); c++) begin
`else
    for (int c = 0; c < int'(NUM_CH); c++)
      for (int i = 0; i < int'(n); i++) begin
`endif
        e.addr    = base + (64'(c) << CH_SHIFT) + (64'(i) << BURST_SHIFT);
        e.ch      = CH_W'(c);
        e.last_ch = (i == int'(n) - 1);
        e.last    = (i == int'(n) - 1) && (c == int'(NUM_CH) - 1);
        sb_q.push_back(e);
      end
  endtask

  // Scoreboard: compare the presented address each cycle, pop on handshake.
  always @(negedge aclk) begin
    if (o_addr_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_addr actual=%h required=none", o_addr);
      end else begin
        chk("addr_ch_flags", {4'h0, o_addr, o_addr_ch, o_addr_last_ch, o_addr_last},
            {4'h0, sb_q[0]});
        if (o_addr_ready) begin
          void'(sb_q.pop_front());
          hs_cnt++;
        end
      end
      if (o_addr_last === 1'b1) begin
        last_seen = 1'b1;
        last_addr = o_addr;
      end
    end
  end

  task automatic drive_cmd(input logic [63:0] base, input int unsigned n);
    chk("cmd_ready_pre", 72'(i_cmd_ready), 72'(1));
    push_cmd(base, n);
    last_seen    = 1'b0;
    i_cmd_valid  = 1'b1;
    i_cmd_base   = base;
    i_cmd_nburst = NBURST_W'(n);
    @(posedge aclk);
    #1;
    i_cmd_valid = 1'b0;
    chk("first_valid", 72'(o_addr_valid), 72'(n != 0));
    chk("busy_after_accept", 72'(o_busy), 72'(n != 0));
    chk("ready_after_accept", 72'(i_cmd_ready), 72'(n == 0));
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int exp_cnt,
                       input logic [63:0] exp_last);
    int start;
    int cyc;
    bit done;
    start = hs_cnt;
    cyc   = 0;
    done  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!o_addr_valid) begin
        done = 1'b1;
        break;
      end
      o_addr_ready = !(k >= stall_at && k < stall_at + stall_len);
      @(posedge aclk);
      #1;
      cyc++;
    end
    o_addr_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=valid_stuck required=valid_low");
    end
    chk("handshake_count", 72'(hs_cnt - start), 72'(exp_cnt));
    chk("cycle_count", 72'(cyc), 72'(exp_cnt + stall_len));
    chk("scoreboard_empty", 72'(sb_q.size()), 72'(0));
    chk("last_seen", 72'(last_seen), 72'(exp_cnt != 0));
    if (exp_cnt != 0) chk("last_addr", 72'(last_addr), 72'(exp_last));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    hs_cnt       = 0;
    last_seen    = 1'b0;
    last_addr    = '0;
    areset       = 1'b1;
    i_cmd_valid  = 1'b0;
    i_cmd_base   = '0;
    i_cmd_nburst = '0;
    o_addr_ready = 1'b1;

    vecs[0] = '{64'h0000_0001_0000_0040, 2, 0, 0, 8,  64'h0000_0001_3000_1040};
    vecs[1] = '{64'h0000_0001_0000_0040, 2, 3, 3, 8,  64'h0000_0001_3000_1040};
    vecs[2] = '{64'hFFFF_FFFF_F000_0000, 1, 0, 0, 4,  64'h0000_0000_2000_0000};
    vecs[3] = '{64'h0000_0000_8000_0000, 3, 5, 2, 12, 64'h0000_0000_B000_2000};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("ready_in_reset", 72'(i_cmd_ready), 72'(0));
    chk("reset_outputs", {4'h0, o_addr_valid, o_addr, o_addr_ch, o_addr_last_ch, o_addr_last, o_busy},
        72'(0));
    areset = 1'b0;
    #1;
    chk("ready_after_reset", 72'(i_cmd_ready), 72'(1));

    foreach (vecs[v]) begin
      drive_cmd(vecs[v].base, vecs[v].n);
      drain(vecs[v].stall_at, vecs[v].stall_len, vecs[v].exp_cnt, vecs[v].exp_last);
    end

    // Empty command immediately followed by a real one
    drive_cmd(64'h0000_0000_0000_1000, 0);
    chk("empty_no_valid", 72'(o_addr_valid), 72'(0));
    drive_cmd(64'h0000_0000_4000_0000, 1);
    drain(0, 0, 4, 64'h0000_0000_7000_0000);

    // Reset after the third handshake aborts the command
    drive_cmd(64'h0000_0001_0000_0040, 2);
    begin
      int start;
      start = hs_cnt;
      for (int k = 0; k < 50; k++) begin
        if (hs_cnt - start >= 3) break;
        @(posedge aclk);
        #1;
      end
      chk("abort_hs_count", 72'(hs_cnt - start), 72'(3));
    end
    areset = 1'b1;
    #1;
    chk("ready_during_reset", 72'(i_cmd_ready), 72'(0));
    @(posedge aclk);
    #1;
    chk("abort_outputs", {4'h0, o_addr_valid, o_addr, o_addr_ch, o_addr_last_ch, o_addr_last, o_busy},
        72'(0));
    areset = 1'b0;
    sb_q.delete();
    #1;
    chk("ready_after_abort", 72'(i_cmd_ready), 72'(1));
    repeat (5) @(posedge aclk);
    #1;
    chk("abort_no_last", 72'(last_seen), 72'(0));
    chk("abort_idle_valid", 72'(o_addr_valid), 72'(0));

    // Recovery after abort
    drive_cmd(vecs[0].base, vecs[0].n);
    drain(0, 0, vecs[0].exp_cnt, vecs[0].exp_last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
